// File: rtl/sram_controller.sv
// Stretches each 32-bit data-memory access into two 16-bit async-SRAM accesses, low half first.
// Latency: 2*ACC_CYCLES+1 cycles from request to the one-cycle DONE pulse on ready.
module sram_controller #(
    parameter int          ACC_CYCLES = 2,
    parameter logic [31:0] MEM_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(ACC_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [16:0] wa_q, wa_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] offset;
    logic        last;
    logic        active;
    logic        drive_dq;
    logic [15:0] dq_out;
    logic        unused_bits;

    assign offset      = address - MEM_BASE;
    assign unused_bits = ^{offset[31:19], offset[1:0]};
    assign last        = (cnt_q == CNT_LAST);
    assign active      = (state_q == S_LO) || (state_q == S_HI);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (rd_en || wr_en) begin
                    op_wr_d = wr_en;
                    wa_d    = offset[18:2];
                    wd_d    = writeData;
                    cnt_d   = 4'd0;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (last) begin
                    if (!op_wr_q) rdata_d[15:0] = SRAM_DQ;
                    cnt_d   = 4'd0;
                    state_d = S_HI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HI: begin
                if (last) begin
                    if (!op_wr_q) rdata_d[31:16] = SRAM_DQ;
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            wa_q    <= 17'd0;
            wd_q    <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
        end
    end

    // WE_N rises on the last cycle of each half so the address only moves with WE deasserted.
    assign ready     = ~(rd_en | wr_en) | (state_q == S_DONE);
    assign readData  = rdata_q;
    assign SRAM_ADDR = active ? {wa_q, (state_q == S_HI)} : 18'd0;
    assign SRAM_OE_N = ~(active & ~op_wr_q);
    assign SRAM_WE_N = ~(active & op_wr_q & ~last);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign drive_dq = active & op_wr_q;
    assign dq_out   = (state_q == S_HI) ? wd_q[31:16] : wd_q[15:0];
    assign SRAM_DQ  = drive_dq ? dq_out : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed vector table, reset/back-to-back sequences,
// then random accesses scored against a word-level memory model and an SRAM device model.
module tb_sram_controller;

    localparam int          ACC  = 2;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          LAT  = 2 * ACC + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, writeData;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    int n_vec = 0;
    int n_bad = 0;

    sram_controller #(.ACC_CYCLES(ACC), .MEM_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .writeData(writeData),
        .readData(readData), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    always #5 clk = ~clk;

    // Async SRAM device: a write commits when WE_N rises with the address unchanged.
    logic [15:0] sram [262144];
    logic        prev_we = 1'b1;
    logic [17:0] prev_addr = '0;
    logic [15:0] prev_dq = '0;

    assign sram_dq = (!oe_n && we_n && !ce_n) ? sram[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (!prev_we && we_n && sram_addr == prev_addr) sram[prev_addr] = prev_dq;
        prev_we   = we_n;
        prev_addr = sram_addr;
        prev_dq   = sram_dq;
    end

    // Word-level reference: what the CPU should see, independent of halfword sequencing.
    logic [31:0] ref_mem [131072];
    logic [31:0] exp_rd = '0;

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) & 32'h1FFFF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output logic [17:0] m_lo, output logic [31:0] m_rd);
        int wi;
        wi = word_of(a);
        if (w) ref_mem[wi] = d;
        else   exp_rd = ref_mem[wi];
        m_lo = 18'(wi * 2);
        m_rd = exp_rd;
    endtask

    // Called just after a rising edge with the DUT idle.
    task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic keep,
                              input logic [17:0] exp_lo, input logic [31:0] exp_rdata,
                              input string tag);
        int          k = 0;
        bit          done = 0;
        int          ctl_bad = 0;
        logic [17:0] lo_a = '0;
        logic [17:0] hi_a = '0;
        logic        e_we, e_oe, lst;
        rd_en = r; wr_en = w; address = a; writeData = d;
        while (!done && k < 40) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
                check({tag, ".rdata"}, readData, exp_rdata);
            end else begin
                if (k == 1)       lo_a = sram_addr;
                if (k == ACC + 1) hi_a = sram_addr;
                if (k == 0) begin
                    e_we = 1'b1; e_oe = 1'b1;
                end else begin
                    lst  = (k == ACC) || (k == 2 * ACC);
                    e_we = !(w && !lst);
                    e_oe = w;
                end
                if (we_n !== e_we || oe_n !== e_oe || ce_n !== 1'b0) ctl_bad++;
                k++;
            end
        end
        check({tag, ".lat"}, 32'(k), 32'(LAT));
        check({tag, ".addr_lo"}, 32'(lo_a), 32'(exp_lo));
        check({tag, ".addr_hi"}, 32'(hi_a), 32'(exp_lo) + 32'd1);
        check({tag, ".ctl"}, 32'(ctl_bad), 32'd0);
        @(posedge clk);
        #1;
        if (!keep) begin
            rd_en = 1'b0; wr_en = 1'b0;
        end
    endtask

    task automatic do_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic keep, input bit has_exp, input logic [17:0] t_lo,
                         input logic [31:0] t_rd, input string tag);
        logic [17:0] m_lo;
        logic [31:0] m_rd;
        int          wi;
        model_step(w, a, d, m_lo, m_rd);
        if (has_exp) run_access(r, w, a, d, keep, t_lo, t_rd, tag);
        else         run_access(r, w, a, d, keep, m_lo, m_rd, tag);
        if (w) begin
            wi = word_of(a);
            check({tag, ".mem"}, {sram[2 * wi + 1], sram[2 * wi]}, ref_mem[wi]);
        end
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [17:0] exp_lo;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        vec_t        tbl [8];
        logic [31:0] ra, rdv;
        logic        rr, rw, keep;
        int          op;

        tbl[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2,       32'h00000000};
        tbl[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        18'd2,       32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b0, 32'd1024, 32'h0,        18'd0,       32'h00000000};
        tbl[3] = '{1'b1, 1'b0, 32'd5024, 32'h0,        18'd2000,    32'h00000000};
        tbl[4] = '{1'b1, 1'b1, 32'd1036, 32'h12345678, 18'd6,       32'h00000000};
        tbl[5] = '{1'b1, 1'b0, 32'd1036, 32'h0,        18'd6,       32'h12345678};
        tbl[6] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE,   32'h12345678};
        tbl[7] = '{1'b1, 1'b0, 32'd1022, 32'h0,        18'h3FFFE,   32'hCAFEF00D};

        for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
        for (int i = 0; i < 131072; i++) ref_mem[i] = 32'h0;

        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; writeData = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset.rdata", readData, 32'h0);
        check("reset.ctl", {26'd0, we_n, oe_n, ce_n, ub_n, lb_n, ready}, {26'd0, 6'b110001});
        check("reset.addr", 32'(sram_addr), 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle", {29'd0, ready, we_n, oe_n}, 32'd7);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++)
            do_op(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, 1'b1,
                  tbl[i].exp_lo, tbl[i].exp_rd, $sformatf("vec%0d", i));

        // Back-to-back write then read with no extra gap.
        do_op(1'b0, 1'b1, 32'd1032, 32'h0BADF00D, 1'b1, 1'b1, 18'd4, 32'hCAFEF00D, "b2b.wr");
        do_op(1'b1, 1'b0, 32'd1032, 32'h0,        1'b0, 1'b1, 18'd4, 32'h0BADF00D, "b2b.rd");

        // Reset in the first HI cycle of a write leaves only the low half written.
        do_op(1'b0, 1'b1, 32'd1040, 32'hAAAABBBB, 1'b0, 1'b1, 18'd8, 32'h0BADF00D, "pre.wr");
        wr_en = 1'b1; address = 32'd1040; writeData = 32'h11112222;
        repeat (ACC + 2) @(negedge clk);
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        check("rst_mid.ctl", {29'd0, ready, we_n, oe_n}, 32'd7);
        check("rst_mid.rdata", readData, 32'h0);
        check("rst_mid.addr", 32'(sram_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ref_mem[word_of(32'd1040)] = 32'hAAAA2222;
        exp_rd = 32'h0;
        do_op(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 1'b1, 18'd8, 32'hAAAA2222, "rst_mid.rd");

        // Random traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 4);
            rw = (op >= 2);
            rr = (op != 2 && op != 3);
            if ($urandom_range(0, 7) == 0) ra = BASE - 32'(4 * $urandom_range(1, 4));
            else ra = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
            rdv  = $urandom;
            keep = 1'($urandom_range(0, 1));
            do_op(rr, rw, ra, rdv, keep, 1'b0, 18'd0, 32'd0, $sformatf("rnd%0d", i));
        end
        rd_en = 1'b0; wr_en = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule
